// File: rtl/data_sram_if.sv
// SRAM-like data bus between the CPU pipeline (master) and a data memory (slave).
// A request is accepted on a rising edge where req && addr_ok; each data_ok pulse completes the oldest accepted request.
interface data_sram_if;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
             data_sram_wstrb, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
             data_sram_wstrb, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// In-order responder for the data SRAM bus: queues up to DEPTH requests and answers
// each one LATENCY cycles after it reaches the head, backed by a word-organised RAM.
module data_sram_responder #(
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 2,
   parameter int LATENCY = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       resp_stall,
   data_sram_if.slave bus
);
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int HW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [HW-1:0]   HEAD_LOAD = HW'(LATENCY - 1);
   localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(DEPTH);

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] idx;
      logic [3:0]        wstrb;
      logic [31:0]       wdata;
   } entry_t;

   entry_t            fifo_q [DEPTH];
   logic [PW-1:0]     head_ptr_q, head_ptr_d;
   logic [PW-1:0]     tail_ptr_q, tail_ptr_d;
   logic [CNTW-1:0]   count_q, count_d;
   logic [HW-1:0]     head_cnt_q, head_cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       mem [2**ADDR_W];

   entry_t head, new_entry;
   logic   pop, accept;
   logic   unused_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign pop    = (count_q != '0) && (head_cnt_q == '0) && !resp_stall;
   assign accept = bus.data_sram_req && bus.data_sram_addr_ok;

   assign bus.data_sram_addr_ok = (count_q < CNT_MAX) || pop;
   assign bus.data_sram_data_ok = pop;
   assign bus.data_sram_rdata   = rdata_d;

   // Size and the sub-word/high address bits carry no meaning for a word RAM.
   assign unused_ok = ^{bus.data_sram_size, bus.data_sram_addr[1:0],
                        bus.data_sram_addr[31:ADDR_W+2]};

   always_comb begin
      head            = fifo_q[head_ptr_q];
      new_entry.wr    = bus.data_sram_wr;
      new_entry.idx   = bus.data_sram_addr[ADDR_W+1:2];
      new_entry.wstrb = bus.data_sram_wstrb;
      new_entry.wdata = bus.data_sram_wdata;

      rdata_d = rdata_q;
      if (pop) rdata_d = head.wr ? 32'h0 : mem[head.idx];

      head_ptr_d = pop    ? ptr_inc(head_ptr_q) : head_ptr_q;
      tail_ptr_d = accept ? ptr_inc(tail_ptr_q) : tail_ptr_q;

      count_d = count_q;
      if (accept && !pop)      count_d = count_q + 1'b1;
      else if (!accept && pop) count_d = count_q - 1'b1;

      // A new head (fresh accept into an empty queue, or promotion after a pop) restarts the latency.
      head_cnt_d = head_cnt_q;
      if ((accept && count_q == '0) || (pop && (count_q > CNTW'(1) || accept)))
         head_cnt_d = HEAD_LOAD;
      else if (count_q != '0 && head_cnt_q != '0)
         head_cnt_d = head_cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         head_ptr_q <= '0;
         tail_ptr_q <= '0;
         count_q    <= '0;
         head_cnt_q <= '0;
         rdata_q    <= '0;
      end else begin
         head_ptr_q <= head_ptr_d;
         tail_ptr_q <= tail_ptr_d;
         count_q    <= count_d;
         head_cnt_q <= head_cnt_d;
         rdata_q    <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) fifo_q[tail_ptr_q] <= new_entry;
   end

   // Writes commit only when the entry completes, so ordered completions give read-after-write.
   always_ff @(posedge clk) begin
      if (resetn && pop && head.wr) begin
         for (int b = 0; b < 4; b++) begin
            if (head.wstrb[b]) mem[head.idx][8*b +: 8] <= head.wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: randomized traffic against a word-memory reference model,
// plus directed latency, stall, back-pressure and reset scenarios.
module tb_data_sram_responder;
   localparam int AW1 = 6;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic stall1 = 1'b0;
   logic stall3 = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;

   logic [31:0] exp_q [$];
   int          dok_cyc [$];
   logic [31:0] mem_m [2**AW1];

   data_sram_if b1 ();
   data_sram_if b3 ();

   data_sram_responder #(.ADDR_W(AW1), .DEPTH(2), .LATENCY(1)) u_dut (
      .clk(clk), .resetn(resetn), .resp_stall(stall1), .bus(b1)
   );

   data_sram_responder #(.ADDR_W(4), .DEPTH(2), .LATENCY(3)) u_dut3 (
      .clk(clk), .resetn(resetn), .resp_stall(stall3), .bus(b3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: memory state after all earlier accepted writes gives each read's answer.
   function automatic void model_accept(input logic wr, input logic [31:0] addr,
                                        input logic [3:0] strb, input logic [31:0] wd);
      int idx;
      idx = int'(addr[AW1+1:2]);
      if (wr) begin
         exp_q.push_back(32'h0);
         for (int b = 0; b < 4; b++) if (strb[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
         exp_q.push_back(mem_m[idx]);
      end
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input bit track, output int acc);
      int guard;
      guard = 0;
      b1.data_sram_req   = 1'b1;
      b1.data_sram_wr    = wr;
      b1.data_sram_size  = 2'd2;
      b1.data_sram_addr  = addr;
      b1.data_sram_wstrb = strb;
      b1.data_sram_wdata = wd;
      @(negedge clk);
      while (!b1.data_sram_addr_ok && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      acc = cyc;
      if (guard >= 100) begin
         checks++;
         failures++;
         $display("FAIL addr_ok_timeout: addr_ok stayed 0 for %0d cycles, required 1", guard);
         acc = -1;
      end else if (track) begin
         model_accept(wr, addr, strb, wd);
      end
      @(posedge clk);
      #1;
      b1.data_sram_req = 1'b0;
   endtask

   // LATENCY=3 instance: one request, stall over offsets sf..st, data_ok expected at offset expk.
   task automatic req3(input logic wr, input logic [31:0] wd, input int sf, input int st,
                       input int expk, input logic [31:0] expv);
      b3.data_sram_req   = 1'b1;
      b3.data_sram_wr    = wr;
      b3.data_sram_size  = 2'd2;
      b3.data_sram_addr  = 32'h0;
      b3.data_sram_wstrb = 4'hF;
      b3.data_sram_wdata = wd;
      @(negedge clk);
      check("l3_addr_ok", b3.data_sram_addr_ok, 32'h1);
      @(posedge clk);
      #1;
      b3.data_sram_req = 1'b0;
      for (int k = 1; k <= expk; k++) begin
         stall3 = (k >= sf && k <= st);
         @(negedge clk);
         check($sformatf("l3_data_ok_off%0d", k), b3.data_sram_data_ok, (k == expk) ? 32'h1 : 32'h0);
         if (k == expk) check("l3_rdata", b3.data_sram_rdata, expv);
         @(posedge clk);
         #1;
      end
      stall3 = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en && b1.data_sram_data_ok) begin
         dok_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_data_ok: data_ok=1 rdata=0x%08h at cycle %0d, required no response",
                     b1.data_sram_rdata, cyc);
         end else begin
            check("rdata", b1.data_sram_rdata, exp_q.pop_front());
         end
      end
   end

   initial begin
      int a0, a1, a2, s, n0;
      int a [4];
      b1.data_sram_req = 1'b0; b1.data_sram_wr = 1'b0; b1.data_sram_size = 2'd0;
      b1.data_sram_addr = '0; b1.data_sram_wstrb = '0; b1.data_sram_wdata = '0;
      b3.data_sram_req = 1'b0; b3.data_sram_wr = 1'b0; b3.data_sram_size = 2'd0;
      b3.data_sram_addr = '0; b3.data_sram_wstrb = '0; b3.data_sram_wdata = '0;

      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      check("rst_addr_ok", b1.data_sram_addr_ok, 32'h1);
      check("rst_data_ok", b1.data_sram_data_ok, 32'h0);
      check("rst_rdata", b1.data_sram_rdata, 32'h0);
      check("rst3_addr_ok", b3.data_sram_addr_ok, 32'h1);
      @(posedge clk);
      #1;

      // LATENCY=3: write then plain read, then read with stall across offsets 2..4.
      req3(1'b1, 32'hCAFE0001, 0, -1, 3, 32'h0);
      req3(1'b0, 32'h0, 0, -1, 3, 32'hCAFE0001);
      req3(1'b0, 32'h0, 2, 4, 5, 32'hCAFE0001);

      // Preload every word; words 0..3 hold 1..4.
      for (int i = 0; i < 2**AW1; i++)
         issue(1'b1, 32'(i * 4), 4'hF, (i < 4) ? 32'(i + 1) : $urandom(), 1'b1, s);
      drain();

      issue(1'b1, 32'h40, 4'hF, 32'h12345678, 1'b1, s);
      issue(1'b0, 32'h40, 4'h0, 32'h0, 1'b1, s);
      @(negedge clk);
      check("raw_data_ok", b1.data_sram_data_ok, 32'h1);
      check("raw_rdata", b1.data_sram_rdata, 32'h12345678);
      @(posedge clk);
      #1;

      issue(1'b1, 32'h40, 4'b0010, 32'h0000AB00, 1'b1, s);
      issue(1'b0, 32'h40, 4'h0, 32'h0, 1'b1, s);
      @(negedge clk);
      check("byte_data_ok", b1.data_sram_data_ok, 32'h1);
      check("byte_rdata", b1.data_sram_rdata, 32'h1234AB78);
      @(posedge clk);
      #1;
      drain();

      // Back-to-back reads at full throughput.
      dok_cyc.delete();
      for (int k = 0; k < 4; k++) issue(1'b0, 32'(k * 4), 4'h0, 32'h0, 1'b1, a[k]);
      repeat (3) @(posedge clk);
      #1;
      for (int k = 1; k < 4; k++) check($sformatf("b2b_accept%0d", k), 32'(a[k]), 32'(a[0] + k));
      check("b2b_count", 32'(dok_cyc.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         check($sformatf("b2b_dok%0d", k), (dok_cyc.size() > k) ? 32'(dok_cyc[k]) : 32'hFFFFFFFF,
               32'(a[0] + 1 + k));
      drain();

      // Stall holds responses; the full queue accepts again in the first pop cycle.
      dok_cyc.delete();
      stall1 = 1'b1;
      fork
         begin
            issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b1, a0);
            issue(1'b0, 32'h14, 4'h0, 32'h0, 1'b1, a1);
            issue(1'b0, 32'h18, 4'h0, 32'h0, 1'b1, a2);
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            s = cyc;
            stall1 = 1'b0;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      check("stall_accept1", 32'(a1), 32'(a0 + 1));
      check("stall_accept3", 32'(a2), 32'(s));
      check("stall_count", 32'(dok_cyc.size()), 32'd3);
      check("stall_first_dok", (dok_cyc.size() > 0) ? 32'(dok_cyc[0]) : 32'hFFFFFFFF, 32'(s));
      drain();

      // Random traffic.
      for (int n = 0; n < 120; n++) begin
         issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) & 32'hFC,
               4'($urandom_range(0, 15)), $urandom(), 1'b1, s);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      // Reset with two outstanding requests: neither completes, the write is lost.
      stall1 = 1'b1;
      issue(1'b1, 32'h20, 4'hF, 32'hDEADBEEF, 1'b0, s);
      issue(1'b0, 32'h20, 4'h0, 32'h0, 1'b0, s);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      stall1 = 1'b0;
      n0 = dok_cyc.size();
      @(negedge clk);
      check("post_rst_addr_ok", b1.data_sram_addr_ok, 32'h1);
      check("post_rst_data_ok", b1.data_sram_data_ok, 32'h0);
      check("post_rst_rdata", b1.data_sram_rdata, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_no_dok", 32'(dok_cyc.size()), 32'(n0));
      issue(1'b0, 32'h20, 4'h0, 32'h0, 1'b1, s);
      @(negedge clk);
      check("aborted_write_data_ok", b1.data_sram_data_ok, 32'h1);
      check("aborted_write_word", b1.data_sram_rdata, mem_m[8]);
      @(posedge clk);
      #1;
      drain();
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave (responder) end of the sram-like data interface that the CPU pipeline drives: EX stage issues requests, MEM stage consumes data_ok/rdata.
- Accepts requests with an addr_ok handshake and queues them in order, up to DEPTH outstanding.
- Returns each request's data_ok pulse and read data after a fixed LATENCY, with an optional external stall.
- Backed by an internal word-organised RAM. Used as the data-memory model in simulation and as the on-chip data RAM front end.

Parameters:
ADDR_W, 16, word-index width; RAM holds 2^ADDR_W 32-bit words, indexed by data_sram_addr[ADDR_W+1:2]
DEPTH, 2, max outstanding accepted-but-unanswered requests (>=1)
LATENCY, 1, cycles from acceptance or head promotion to earliest data_ok (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  synchronous active-low reset
data_sram_req  in  1  request valid
data_sram_wr  in  1  1=write, 0=read
data_sram_size  in  2  0=byte, 1=half, 2=word; recorded only, byte enables come from wstrb
data_sram_addr  in  32  byte address; bits [1:0] and above ADDR_W+1 ignored
data_sram_wstrb  in  4  byte write enables for writes, ignored for reads
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  request accepted this cycle when req&&addr_ok
data_sram_data_ok  out  1  one-cycle pulse completing the oldest outstanding request
data_sram_rdata  out  32  read data, valid with data_ok for reads; 0 for write completions
resp_stall  in  1  when 1, suppresses data_ok (verification/back-pressure hook)

Behaviour:
- Reset (resetn=0 at a clock edge):
  - Queue emptied, head counter cleared.
  - data_ok=0, rdata=0; addr_ok is combinational and becomes 1 once the queue is empty.
  - RAM contents are not cleared.
  - Requests in flight at reset are discarded: no data_ok, no RAM write.
- Queue: in-order FIFO of DEPTH entries {wr, word index, wstrb, wdata}; count 0..DEPTH; pointers wrap modulo DEPTH.
- pop = (count>0) && (head_cnt==0) && !resp_stall.
- addr_ok = (count<DEPTH) || pop, combinational. A full queue accepts in the same cycle a pop occurs.
- Accept at edge when req&&addr_ok: entry written at tail, count+1; with a simultaneous pop, count is unchanged.
- Head counter:
  - Loaded with LATENCY-1 when an entry becomes head, i.e. on accept into an empty queue, or on pop when count>1 (next entry promoted).
  - Decrements by 1 per cycle while count>0, head_cnt>0, regardless of resp_stall. Saturates at 0.
- Timing:
  - Request accepted in cycle N into an empty queue: data_ok earliest in cycle N+LATENCY.
  - Promoted head: data_ok earliest LATENCY cycles after the previous pop cycle.
  - LATENCY=1 with no stall sustains one data_ok per cycle.
- data_ok = pop, combinational from registered state plus resp_stall.
- rdata, combinational in the pop cycle:
  - Head read: RAM[head index].
  - Head write: 0.
  - No pop: rdata holds its last registered value (rdata is a registered copy updated only on pop; the driven value is RAM word when popping a read).
- Writes:
  - RAM updated at the edge ending the pop cycle of the write entry, only bytes with wstrb[i]=1.
  - wstrb=0 completes with data_ok and leaves RAM unchanged.
- Ordering:
  - Completions strictly in acceptance order.
  - A read accepted after a write to the same word returns the written data, since writes commit at completion and completions are ordered.
  - A read popping in the same cycle that a different entry would write cannot happen (one pop per cycle).
- No cancellation: every accepted request is answered even if the pipeline flushes. Discarding stale responses is the requester's duty.
- req deasserted: no state change except counter/pop progress. The interface must not depend on requester holding signals after acceptance.

Test Plan:
- Write 0x12345678 to addr 0x40 wstrb=4'hF, then read 0x40 -> write data_ok with rdata=0; read data_ok LATENCY cycles after its acceptance with rdata=0x12345678.
- Byte write wdata=0x0000AB00 wstrb=4'b0010 to 0x40 over 0x12345678, then read 0x40 -> rdata=0x1234AB78.
- LATENCY=1, DEPTH=2, req held high for 4 reads of 0x0,0x4,0x8,0xC preloaded 1..4 -> addr_ok every cycle, data_ok in 4 consecutive cycles, rdata 1,2,3,4 in order.
- resp_stall=1 with 3 back-to-back reqs -> first two accepted, addr_ok=0 on third until stall drops. Same cycle as first data_ok, third accepted (addr_ok=1); no data_ok while stalled.
- LATENCY=3 single read accepted cycle 10 -> data_ok exactly in cycle 13; with resp_stall high in cycles 12-14 -> data_ok in cycle 15.
- Assert resetn=0 with 2 outstanding (one write) -> no data_ok afterwards, rdata=0, addr_ok=1 next cycle, RAM word of the aborted write unchanged.
